// File: rtl/hann_pkg.sv
// Shared defaults and elaboration-time helpers for the Hann window stage.
// Used by hann_coef_rom and hann_window_multiplier.
package hann_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_WINDOW_LEN = 1024;
    localparam int DEF_COEF_WIDTH = 16;

    localparam real PI = 3.14159265358979323846;

    // Ceiling log2, valid for value >= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Cosine by Taylor series after reduction to [-pi, pi].
    function automatic real cos_series(input real angle);
        real x;
        real term;
        real sum;
        x = angle;
        while (x > PI) x = x - 2.0 * PI;
        while (x < -PI) x = x + 2.0 * PI;
        term = 1.0;
        sum  = 1.0;
        for (int k = 1; k <= 20; k++) begin
            term = -term * x * x / (real'(2 * k - 1) * real'(2 * k));
            sum  = sum + term;
        end
        return sum;
    endfunction

    // round(2^(coef_width-1) * 0.5 * (1 - cos(2*pi*n/(len-1)))).
    // Evaluated on the lower half index so the table is exactly symmetric.
    function automatic int hann_coef(input int n, input int len, input int coef_width);
        int  m;
        real w;
        real scaled;
        m      = (n < len / 2) ? n : (len - 1 - n);
        w      = 0.5 * (1.0 - cos_series(2.0 * PI * real'(m) / real'(len - 1)));
        scaled = w * real'(longint'(1) << (coef_width - 1));
        if (scaled < 0.0) scaled = 0.0;
        return $rtoi(scaled + 0.5);
    endfunction

endpackage

// File: rtl/hann_coef_rom.sv
// Hann coefficient ROM with registered output (1-cycle read).
// Build option HANN_HALF_ROM_EN: store only the first half of the frame and
// mirror the upper-half addresses onto it.
module hann_coef_rom
    import hann_pkg::*;
#(
    parameter int WINDOW_LEN = DEF_WINDOW_LEN,
    parameter int COEF_WIDTH = DEF_COEF_WIDTH,
    parameter int ADDR_WIDTH = clog2(WINDOW_LEN)
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [COEF_WIDTH-1:0] coef
);

`ifdef HANN_HALF_ROM_EN
    localparam int DEPTH = WINDOW_LEN / 2;

    logic [ADDR_WIDTH-2:0] rom_addr;

    // N is a power of two, so N-1-n for the upper half is the bitwise complement.
    always_comb begin
        rom_addr = addr[ADDR_WIDTH-1] ? ~addr[ADDR_WIDTH-2:0] : addr[ADDR_WIDTH-2:0];
    end
`else
    localparam int DEPTH = WINDOW_LEN;

    logic [ADDR_WIDTH-1:0] rom_addr;

    // Full table, addressed directly by frame position.
    always_comb begin
        rom_addr = addr;
    end
`endif

    logic [COEF_WIDTH-1:0] rom [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        assign rom[i] = COEF_WIDTH'(hann_coef(i, WINDOW_LEN, COEF_WIDTH));
    end

    // Registered read.
    always_ff @(posedge clk) begin
        coef <= rom[rom_addr];
    end

endmodule

// File: rtl/hann_window_multiplier.sv
// Streaming Hann window: o_data = round(i_data * w[n]), fixed 3-cycle latency.
// Frame position is tracked internally; o_last marks index N-1.
// Build option HANN_HALF_ROM_EN selects the half-size coefficient ROM.
module hann_window_multiplier
    import hann_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int WINDOW_LEN = DEF_WINDOW_LEN,
    parameter int COEF_WIDTH = DEF_COEF_WIDTH
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic signed [DATA_WIDTH-1:0] i_data,
    input  logic                         i_valid,
    output logic signed [DATA_WIDTH-1:0] o_data,
    output logic                         o_valid,
    output logic                         o_last
);

    localparam int ADDR_WIDTH = clog2(WINDOW_LEN);
    localparam int PROD_WIDTH = DATA_WIDTH + COEF_WIDTH + 1;
    localparam logic signed [PROD_WIDTH-1:0] ROUND_BIAS =
        {{(PROD_WIDTH - 1){1'b0}}, 1'b1} << (COEF_WIDTH - 2);

    logic [ADDR_WIDTH-1:0]         frame_idx;

    logic signed [DATA_WIDTH-1:0]  s1_data;
    logic [COEF_WIDTH-1:0]         s1_coef;
    logic signed [COEF_WIDTH:0]    s1_coef_ext;
    logic                          s1_valid;
    logic                          s1_last;

    logic signed [PROD_WIDTH-1:0]  s2_prod;
    logic                          s2_valid;
    logic                          s2_last;

    assign s1_coef_ext = {1'b0, s1_coef};

    // Coefficient lookup; its output register forms part of stage 1.
    hann_coef_rom #(
        .WINDOW_LEN (WINDOW_LEN),
        .COEF_WIDTH (COEF_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_coef_rom (
        .clk  (i_clk),
        .addr (frame_idx),
        .coef (s1_coef)
    );

    // Frame position: advances only on accepted samples, wraps naturally at N.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            frame_idx <= '0;
        end else if (i_valid) begin
            frame_idx <= frame_idx + 1'b1;
        end
    end

    // Stage 1: capture sample, valid and end-of-frame flag.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
        end else begin
            s1_valid <= i_valid;
            s1_last  <= i_valid & (&frame_idx);
            if (i_valid) begin
                s1_data <= i_data;
            end
        end
    end

    // Stage 2: signed multiply by the zero-extended unsigned coefficient.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            s2_prod  <= '0;
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            if (s1_valid) begin
                s2_prod <= PROD_WIDTH'(s1_data) * PROD_WIDTH'(s1_coef_ext);
            end
        end
    end

    // Stage 3: round half up and rescale; coef <= 1.0 so truncation cannot overflow.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_data  <= '0;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
        end else begin
            o_valid <= s2_valid;
            o_last  <= s2_last;
            if (s2_valid) begin
                o_data <= DATA_WIDTH'((s2_prod + ROUND_BIAS) >>> (COEF_WIDTH - 1));
            end
        end
    end

endmodule

// File: tb/tb_hann_window_multiplier.sv
// Self-checking bench for hann_window_multiplier (default 32/1024/16 build).
module tb_hann_window_multiplier;

    localparam int N = 1024;

    logic               clk = 1'b0;
    logic               i_reset = 1'b1;
    logic               i_valid = 1'b1;
    logic signed [31:0] i_data = 32'sd12345;
    logic signed [31:0] o_data;
    logic               o_valid;
    logic               o_last;

    int checks = 0;
    int errors = 0;

    logic signed [31:0] cap [N];
    bit                 hist [4096];

    typedef struct {
        int din;
        int idx;
        int exp_data;
    } vec_t;

    vec_t vecs [12];

    always #5 clk = ~clk;

    hann_window_multiplier #(
        .DATA_WIDTH (32),
        .WINDOW_LEN (N),
        .COEF_WIDTH (16)
    ) dut (
        .i_clk   (clk),
        .i_reset (i_reset),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_last  (o_last)
    );

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic reset_dut(input int cycles);
        i_reset = 1'b1;
        i_valid = 1'b0;
        repeat (cycles) @(negedge clk);
        i_reset = 1'b0;
    endtask

    // Streams a constant until o_last (or budget), capturing outputs by frame position.
    task automatic run_frame(input logic signed [31:0] din, input bit gapped,
                             output int n_out, output int first_lat,
                             output int vmis, output int hold_bad);
        int                 cyc;
        bit                 exp_v;
        logic signed [31:0] prev;
        cyc = 0;
        n_out = 0;
        first_lat = -1;
        vmis = 0;
        hold_bad = 0;
        prev = o_data;
        i_data = din;
        while (cyc < 3000) begin
            i_valid = gapped ? (cyc % 2 == 0) : 1'b1;
            hist[cyc] = i_valid;
            @(negedge clk);
            cyc++;
            exp_v = (cyc >= 3) ? hist[cyc-3] : 1'b0;
            if (o_valid !== exp_v) vmis++;
            if (o_valid === 1'b1) begin
                if (first_lat < 0) first_lat = cyc;
                if (n_out < N) cap[n_out] = o_data;
                n_out++;
                if (o_last === 1'b1) break;
            end else begin
                if (o_data !== prev) hold_bad++;
                if (o_last !== 1'b0) vmis++;
            end
            prev = o_data;
        end
        i_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_out;
        int first_lat;
        int vmis;
        int hold_bad;
        int cur_din;
        int bad;
        int cyc;
        int cnt;

        // din, frame index, expected windowed output
        vecs[0]  = '{din: -2147483647, idx: 0,    exp_data: 0};
        vecs[1]  = '{din: -2147483647, idx: 1,    exp_data: 0};
        vecs[2]  = '{din: -2147483647, idx: 2,    exp_data: -65536};
        vecs[3]  = '{din: -2147483647, idx: 256,  exp_data: -1075380223};
        vecs[4]  = '{din: -2147483647, idx: 511,  exp_data: -2147483647};
        vecs[5]  = '{din: -2147483647, idx: 512,  exp_data: -2147483647};
        vecs[6]  = '{din: -2147483647, idx: 767,  exp_data: -1075380223};
        vecs[7]  = '{din: -2147483647, idx: 1021, exp_data: -65536};
        vecs[8]  = '{din: -2147483647, idx: 1023, exp_data: 0};
        vecs[9]  = '{din: 2147483647,  idx: 2,    exp_data: 65536};
        vecs[10] = '{din: 2147483647,  idx: 256,  exp_data: 1075380223};
        vecs[11] = '{din: 2147483647,  idx: 512,  exp_data: 2147483647};

        // Reset held with i_valid high: outputs stay cleared.
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("reset_valid[%0d]", c), o_valid, 0);
            chk($sformatf("reset_last[%0d]", c), o_last, 0);
            chk($sformatf("reset_data[%0d]", c), o_data, 0);
        end
        i_reset = 1'b0;
        i_valid = 1'b0;

        // Table-driven constant-stream frames; new frame whenever din changes.
        cur_din = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 0 || vecs[i].din != cur_din) begin
                cur_din = vecs[i].din;
                reset_dut(2);
                run_frame(cur_din, 1'b0, n_out, first_lat, vmis, hold_bad);
                chk($sformatf("latency din=%0d", cur_din), first_lat, 3);
                chk($sformatf("frame_len din=%0d", cur_din), n_out, N);
                chk($sformatf("valid_pattern din=%0d", cur_din), vmis, 0);
            end
            chk($sformatf("data din=%0d n=%0d", vecs[i].din, vecs[i].idx),
                cap[vecs[i].idx], vecs[i].exp_data);
        end

        // Positive full-scale frame is in cap: symmetry and rising first half.
        bad = 0;
        for (int n = 0; n < N / 2; n++) begin
            if (cap[n] !== cap[N-1-n]) bad++;
        end
        chk("symmetry_mismatches", bad, 0);
        bad = 0;
        for (int n = 1; n < N / 2; n++) begin
            if (cap[n] < cap[n-1]) bad++;
        end
        chk("monotonic_violations", bad, 0);

        // Gapped valid: o_valid follows i_valid by 3, counter ignores gaps.
        reset_dut(2);
        run_frame(32'sd2147483647, 1'b1, n_out, first_lat, vmis, hold_bad);
        chk("gap_valid_pattern", vmis, 0);
        chk("gap_frame_len", n_out, N);
        chk("gap_data_hold", hold_bad, 0);
        chk("gap_data_n512", cap[512], 2147483647);
        chk("gap_data_n0", cap[0], 0);

        // Mid-frame reset at n=600 of the second frame.
        reset_dut(2);
        i_data  = -32'sd2147483647;
        i_valid = 1'b1;
        repeat (N + 600) @(negedge clk);
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        chk("midrst_valid", o_valid, 0);
        chk("midrst_last", o_last, 0);
        cyc = 0;
        while (o_valid !== 1'b1 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk("midrst_latency", cyc, 3);
        chk("midrst_first_data", o_data, 0);
        chk("midrst_first_last", o_last, 0);
        cnt = 1;
        while (o_last !== 1'b1 && cnt < 1100) begin
            @(negedge clk);
            if (o_valid === 1'b1) cnt++;
        end
        chk("midrst_frame_len", cnt, N);
        chk("midrst_last_data", o_data, 0);
        i_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
